// File: rtl/rf_buf_pkg.sv
// Shared definitions for the RF sample buffer: sample/word geometry, channel
// packing order and the capture FSM state encoding.
package rf_buf_pkg;

  localparam int RF_SAMPLE_W = 16;
  localparam int RF_NUM_CH   = 4;
  localparam int RF_WORD_W   = RF_SAMPLE_W * RF_NUM_CH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } rf_state_e;

  // Channel 1 lands in the least significant lane; the reader unpacks identically.
  function automatic logic [RF_WORD_W-1:0] rf_pack(
    input logic [RF_SAMPLE_W-1:0] c1,
    input logic [RF_SAMPLE_W-1:0] c2,
    input logic [RF_SAMPLE_W-1:0] c3,
    input logic [RF_SAMPLE_W-1:0] c4
  );
    return {c4, c3, c2, c1};
  endfunction

endpackage

// File: rtl/rf_word_pack.sv
// Registered pack of the four channel samples into one buffer word, together
// with the write address and strobe.
module rf_word_pack
  import rf_buf_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [RF_SAMPLE_W-1:0] val1_i,
  input  logic [RF_SAMPLE_W-1:0] val2_i,
  input  logic [RF_SAMPLE_W-1:0] val3_i,
  input  logic [RF_SAMPLE_W-1:0] val4_i,
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [RF_WORD_W-1:0]   wr_data_o
);

  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [RF_WORD_W-1:0] wr_data_q;

  // Address and data hold between writes so the buffer side sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= load_i;
      if (load_i) begin
        wr_addr_q <= addr_i;
        wr_data_q <= rf_pack(val1_i, val2_i, val3_i, val4_i);
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/writerf_vals.sv
// Captures one echo frame of four-channel RF samples into the sample buffer.
// Optional sticky overflow flag: define WRITERF_OVF_EN to add the ovf output.
module writerf_vals
  import rf_buf_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 512,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 trig,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_val1,
  input  logic [15:0]          in_val2,
  input  logic [15:0]          in_val3,
  input  logic [15:0]          in_val4,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [63:0]          wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ADDR_W:0]      samples_written
`ifdef WRITERF_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  rf_state_e        state_q, state_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;

  assign in_ready = (state_q == CAPTURE);
  // abort outranks acceptance, so an aborting cycle never produces a write.
  assign accept   = in_valid && in_ready && !abort;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ARMED;
            count_d = '0;
          end
        end
        ARMED: begin
          if (trig) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (in_valid) begin
            count_d = count_q + 1'b1;
            if (count_q == LAST_IDX) state_d = DONE;
          end
        end
        DONE: begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Address wraps naturally in the ADDR_W-bit sum.
  rf_word_pack #(
    .ADDR_W (ADDR_W)
  ) u_pack (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (accept),
    .addr_i    (BASE_A + count_q[ADDR_W-1:0]),
    .val1_i    (in_val1),
    .val2_i    (in_val2),
    .val3_i    (in_val3),
    .val4_i    (in_val4),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  assign busy            = (state_q == ARMED) || (state_q == CAPTURE);
  assign frame_done      = frame_done_q;
  assign samples_written = count_q;

`ifdef WRITERF_OVF_EN
  logic ovf_q;
  logic arm;

  assign arm = (state_q == IDLE) && start && !abort;

  // A sample on the trigger cycle or after the last write has nowhere to go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (arm) begin
      ovf_q <= 1'b0;
    end else if (in_valid && (((state_q == ARMED) && trig) || (state_q == DONE))) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_writerf_vals.sv
// Bench for writerf_vals: two instances (plain frame and wrapping frame) share
// one stimulus stream and are compared against a frame-level reference model.
module tb_writerf_vals;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, trig = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [15:0] in_val1 = '0, in_val2 = '0, in_val3 = '0, in_val4 = '0;

  logic        a_ready, a_wr_en, a_busy, a_done;
  logic [3:0]  a_addr;
  logic [63:0] a_data;
  logic [4:0]  a_sw;
  logic        b_ready, b_wr_en, b_busy, b_done;
  logic [1:0]  b_addr;
  logic [63:0] b_data;
  logic [2:0]  b_sw;
`ifdef WRITERF_OVF_EN
  logic        a_ovf, b_ovf;
`endif

  always #5 clk = ~clk;

  writerf_vals #(.ADDR_W(4), .FRAME_LEN(4), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .trig(trig), .abort(abort),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_val1(in_val1), .in_val2(in_val2), .in_val3(in_val3), .in_val4(in_val4),
    .wr_en(a_wr_en), .wr_addr(a_addr), .wr_data(a_data), .busy(a_busy),
    .frame_done(a_done), .samples_written(a_sw)
`ifdef WRITERF_OVF_EN
    , .ovf(a_ovf)
`endif
  );

  writerf_vals #(.ADDR_W(2), .FRAME_LEN(3), .BASE_ADDR(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .trig(trig), .abort(abort),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_val1(in_val1), .in_val2(in_val2), .in_val3(in_val3), .in_val4(in_val4),
    .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_data), .busy(b_busy),
    .frame_done(b_done), .samples_written(b_sw)
`ifdef WRITERF_OVF_EN
    , .ovf(b_ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance frame phase (0 idle, 1 waiting for trigger,
  // 2 capturing, 3 frame finished) plus the expected registered outputs.
  int          p_fl[2]   = '{4, 3};
  int          p_base[2] = '{0, 3};
  int          p_aw[2]   = '{4, 2};
  int          m_mode[2], m_cnt[2], m_addr[2];
  bit          m_wr[2], m_done[2], m_ovf[2];
  logic [63:0] m_data[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_addr[i] = 0;
      m_wr[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_data[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int nm;
    bit acc;
    bit nd;
    nm  = m_mode[i];
    acc = 0;
    nd  = (m_mode[i] == 3) && !abort;
    if (in_valid && ((m_mode[i] == 1 && trig) || m_mode[i] == 3)) m_ovf[i] = 1;
    if (abort) nm = 0;
    else begin
      case (m_mode[i])
        0: if (start) begin nm = 1; m_cnt[i] = 0; m_ovf[i] = 0; end
        1: if (trig) nm = 2;
        2: if (in_valid) begin
             acc = 1;
             m_addr[i] = (p_base[i] + m_cnt[i]) % (1 << p_aw[i]);
             m_data[i] = {in_val4, in_val3, in_val2, in_val1};
             m_cnt[i]++;
             if (m_cnt[i] == p_fl[i]) nm = 3;
           end
        default: nm = 0;
      endcase
    end
    m_wr[i]   = acc;
    m_done[i] = nd;
    m_mode[i] = nm;
  endtask

  task automatic cmp_inst(input string t, input int i, input logic wr, input logic [63:0] addr,
                          input logic [63:0] data, input logic done, input logic rdy,
                          input logic bsy, input logic [63:0] sw);
    chk({t, "_wr_en"}, {63'd0, wr}, {63'd0, m_wr[i]});
    if (m_wr[i]) chk({t, "_wr_addr"}, addr, 64'(m_addr[i]));
    chk({t, "_wr_data"}, data, m_data[i]);
    chk({t, "_frame_done"}, {63'd0, done}, {63'd0, m_done[i]});
    chk({t, "_in_ready"}, {63'd0, rdy}, {63'd0, m_mode[i] == 2});
    chk({t, "_busy"}, {63'd0, bsy}, {63'd0, (m_mode[i] == 1 || m_mode[i] == 2)});
    chk({t, "_samples_written"}, sw, 64'(m_cnt[i]));
  endtask

  task automatic compare_all();
    cmp_inst("A", 0, a_wr_en, 64'(a_addr), a_data, a_done, a_ready, a_busy, 64'(a_sw));
    cmp_inst("B", 1, b_wr_en, 64'(b_addr), b_data, b_done, b_ready, b_busy, 64'(b_sw));
`ifdef WRITERF_OVF_EN
    chk("A_ovf", {63'd0, a_ovf}, {63'd0, m_ovf[0]});
    chk("B_ovf", {63'd0, b_ovf}, {63'd0, m_ovf[1]});
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit s, input bit t, input bit a, input bit v, input logic [15:0] b);
    start = s; trig = t; abort = a; in_valid = v;
    in_val1 = b; in_val2 = b + 16'd1; in_val3 = b + 16'd2; in_val4 = b + 16'd3;
  endtask

  typedef struct {
    bit s, t, a, v;
    logic [15:0] base;
    bit e_wr;
    int e_addr;
    logic [63:0] e_data;
    bit e_done, e_busy, e_ready;
    int e_sw;
  } vec_t;

  vec_t tbl[8];
  int   bq[$];
  int   nwr;
  int   wa[$];
  bit   pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    tbl[0] = '{1, 0, 0, 0, 16'd0, 0, 0, 64'h0, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 16'd0, 0, 0, 64'h0, 0, 1, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 16'd1, 1, 0, 64'h0004_0003_0002_0001, 0, 1, 1, 1};
    tbl[3] = '{0, 0, 0, 1, 16'd2, 1, 1, 64'h0005_0004_0003_0002, 0, 1, 1, 2};
    tbl[4] = '{0, 0, 0, 1, 16'd3, 1, 2, 64'h0006_0005_0004_0003, 0, 1, 1, 3};
    tbl[5] = '{0, 0, 0, 1, 16'd4, 1, 3, 64'h0007_0006_0005_0004, 0, 0, 0, 4};
    tbl[6] = '{0, 0, 0, 0, 16'd0, 0, 0, 64'h0,                   1, 0, 0, 4};
    tbl[7] = '{0, 0, 0, 0, 16'd0, 0, 0, 64'h0,                   0, 0, 0, 4};

    model_reset();
    #1;
    chk("rst_wr_en", {63'd0, a_wr_en}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_in_ready", {63'd0, a_ready}, 64'd0);
    chk("rst_frame_done", {63'd0, a_done}, 64'd0);
    chk("rst_samples_written", 64'(a_sw), 64'd0);
    chk("rst_wr_data", a_data, 64'd0);
    #11 reset = 1'b1;

    // Basic frame on A; B sees the same stream and wraps 3,0,1.
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].s, tbl[k].t, tbl[k].a, tbl[k].v, tbl[k].base);
      cycle();
      chk("t1_wr_en", {63'd0, a_wr_en}, {63'd0, tbl[k].e_wr});
      if (tbl[k].e_wr) begin
        chk("t1_wr_addr", 64'(a_addr), 64'(tbl[k].e_addr));
        chk("t1_wr_data", a_data, tbl[k].e_data);
      end
      chk("t1_frame_done", {63'd0, a_done}, {63'd0, tbl[k].e_done});
      chk("t1_busy", {63'd0, a_busy}, {63'd0, tbl[k].e_busy});
      chk("t1_in_ready", {63'd0, a_ready}, {63'd0, tbl[k].e_ready});
      chk("t1_samples_written", 64'(a_sw), 64'(tbl[k].e_sw));
      if (b_wr_en) bq.push_back(int'(b_addr));
    end
    chk("t3_wrap_count", 64'(bq.size()), 64'd3);
    if (bq.size() == 3) begin
      chk("t3_wrap_addr0", 64'(bq[0]), 64'd3);
      chk("t3_wrap_addr1", 64'(bq[1]), 64'd0);
      chk("t3_wrap_addr2", 64'(bq[2]), 64'd1);
    end

    // Gapped input: only valid cycles produce writes.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0); cycle();
    nwr = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 7) drive(0, 0, 0, pat[k], 16'(16'h100 + k)); else drive(0, 0, 0, 0, 0);
      cycle();
      if (a_wr_en) begin nwr++; wa.push_back(int'(a_addr)); end
    end
    chk("t2_write_count", 64'(nwr), 64'd4);
    foreach (wa[j]) chk("t2_write_addr", 64'(wa[j]), 64'(j));

    // Abort after two samples with start in the same cycle.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 16'h200); cycle();
    drive(0, 0, 0, 1, 16'h210); cycle();
    drive(1, 0, 1, 1, 16'h220); cycle();
    chk("t4_busy", {63'd0, a_busy}, 64'd0);
    chk("t4_samples_written", 64'(a_sw), 64'd2);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_no_frame_done", {63'd0, a_done}, 64'd0);
    end
    drive(1, 0, 0, 0, 0); cycle();
    chk("t4_sw_cleared", 64'(a_sw), 64'd0);
    drive(0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 16'h300); cycle();
    chk("t4_restart_addr", 64'(a_addr), 64'd0);
    chk("t4_restart_wr", {63'd0, a_wr_en}, 64'd1);
    for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 1, 16'(16'h310 + k)); cycle(); end
    drive(0, 0, 0, 0, 0); cycle(); cycle();

    // Ignored controls and, with the option, overflow around the frame edges.
    drive(0, 1, 0, 1, 0); cycle();
    chk("t5_trig_idle_busy", {63'd0, a_busy}, 64'd0);
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 16'h400); cycle();
    drive(0, 0, 0, 1, 16'h410); cycle();
    chk("t5_armed_no_write", {63'd0, a_wr_en}, 64'd0);
    drive(0, 1, 0, 1, 16'h420); cycle();
    chk("t5_trig_cycle_no_write", {63'd0, a_wr_en}, 64'd0);
    drive(1, 0, 0, 1, 16'h430); cycle();
    drive(1, 1, 0, 1, 16'h440); cycle();
    drive(0, 0, 0, 1, 16'h450); cycle();
    drive(0, 0, 0, 1, 16'h460); cycle();
    drive(0, 0, 0, 1, 16'h470); cycle();
`ifdef WRITERF_OVF_EN
    chk("t5_ovf_set", {63'd0, a_ovf}, 64'd1);
    drive(1, 0, 0, 0, 0); cycle();
    chk("t5_ovf_cleared", {63'd0, a_ovf}, 64'd0);
    drive(0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle();
`endif
    drive(0, 0, 0, 0, 0); cycle(); cycle();

    // Asynchronous reset in the middle of a capture.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 16'h500); cycle();
    #2 reset = 1'b0;
    #1;
    chk("t6_wr_en_async", {63'd0, a_wr_en}, 64'd0);
    chk("t6_in_ready_async", {63'd0, a_ready}, 64'd0);
    chk("t6_busy_async", {63'd0, a_busy}, 64'd0);
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0); cycle();
    for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 1, 16'(16'h600 + 16 * k)); cycle(); end
    drive(0, 0, 0, 0, 0); cycle();
    chk("t6_frame_done", {63'd0, a_done}, 64'd1);
    chk("t6_samples_written", 64'(a_sw), 64'd4);
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      start    = ($urandom_range(0, 9) == 0);
      trig     = ($urandom_range(0, 4) == 0);
      abort    = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_val1  = 16'($urandom);
      in_val2  = 16'($urandom);
      in_val3  = 16'($urandom);
      in_val4  = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
